// File: rtl/fetch_redirect_unit_if.sv
// Branch-control to fetch bundle: next-PC select, stalls and E-side targets in, fetch state and perf counters out.
interface fetch_redirect_unit_if #(
  parameter int CNT_W = 16
);
  logic             StallF;
  logic             StallE;
  logic [1:0]       PCSrc;
  logic [31:0]      PredPCTargetF;
  logic [31:0]      PCTargetE;
  logic [31:0]      PCPlus4E;
  logic [1:0]       BranchOpE;
  logic             CntClr;
  logic [31:0]      PCF;
  logic [31:0]      PCPlus4F;
  logic             BootF;
  logic             RedirectF;
  logic             MisalignF;
  logic [CNT_W-1:0] BranchCnt;
  logic [CNT_W-1:0] MispredCnt;

  modport master (
    output StallF, StallE, PCSrc, PredPCTargetF, PCTargetE, PCPlus4E, BranchOpE, CntClr,
    input  PCF, PCPlus4F, BootF, RedirectF, MisalignF, BranchCnt, MispredCnt
  );

  modport slave (
    input  StallF, StallE, PCSrc, PredPCTargetF, PCTargetE, PCPlus4E, BranchOpE, CntClr,
    output PCF, PCPlus4F, BootF, RedirectF, MisalignF, BranchCnt, MispredCnt
  );
endinterface

// File: rtl/fetch_redirect_unit.sv
// Owns PCF: picks the next fetch address from PCSrc, lets accepted E-stage redirects override StallF,
// and keeps saturating branch/mispredict counters. PCSrc to PCF and RedirectF is one cycle.
module fetch_redirect_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int          CNT_W        = 16
) (
  input logic                   clk,
  input logic                   reset,
  fetch_redirect_unit_if.slave  bus
);

  typedef enum logic [1:0] {BOOT, RUN, REDIRECT} state_t;

  state_t           state;
  logic [31:0]      pcf;
  logic             bootf;
  logic             redirectf;
  logic             misalignf;
  logic [CNT_W-1:0] branch_cnt;
  logic [CNT_W-1:0] mispred_cnt;

  logic [31:0] pc_plus4;
  logic [31:0] next_pc;
  logic        redir_acc;
  logic        load_en;
  logic        branch_ret;

  assign pc_plus4 = pcf + 32'd4;

  always_comb begin
    next_pc = pc_plus4;
    unique case (bus.PCSrc)
      2'b00: next_pc = pc_plus4;
      2'b01: next_pc = bus.PredPCTargetF;
      2'b10: next_pc = bus.PCTargetE;
      2'b11: next_pc = bus.PCPlus4E;
      default: next_pc = pc_plus4;
    endcase
  end

  // An E-side select while E is stalled may still steer fetch, but only counts once E lets go.
  assign redir_acc  = (state != BOOT) && bus.PCSrc[1] && !bus.StallE;
  assign load_en    = (state != BOOT) && (redir_acc || !bus.StallF);
  assign branch_ret = (state != BOOT) && (bus.BranchOpE != 2'b00) && !bus.StallE;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= BOOT;
      pcf         <= RESET_VECTOR;
      bootf       <= 1'b1;
      redirectf   <= 1'b0;
      misalignf   <= 1'b0;
      branch_cnt  <= '0;
      mispred_cnt <= '0;
    end else begin
      unique case (state)
        BOOT: begin
          state     <= RUN;
          bootf     <= 1'b0;
          redirectf <= 1'b0;
        end
        RUN, REDIRECT: begin
          state     <= redir_acc ? REDIRECT : RUN;
          bootf     <= 1'b0;
          redirectf <= redir_acc;
        end
        default: begin
          state     <= RUN;
          bootf     <= 1'b0;
          redirectf <= 1'b0;
        end
      endcase

      if (load_en)
        pcf <= next_pc;

      if (bus.CntClr) begin
        misalignf   <= 1'b0;
        branch_cnt  <= '0;
        mispred_cnt <= '0;
      end else begin
        if (load_en && (next_pc[1:0] != 2'b00))
          misalignf <= 1'b1;
        if (branch_ret && (branch_cnt != {CNT_W{1'b1}}))
          branch_cnt <= branch_cnt + CNT_W'(1);
        if (redir_acc && (mispred_cnt != {CNT_W{1'b1}}))
          mispred_cnt <= mispred_cnt + CNT_W'(1);
      end
    end
  end

  assign bus.PCF        = pcf;
  assign bus.PCPlus4F   = pc_plus4;
  assign bus.BootF      = bootf;
  assign bus.RedirectF  = redirectf;
  assign bus.MisalignF  = misalignf;
  assign bus.BranchCnt  = branch_cnt;
  assign bus.MispredCnt = mispred_cnt;

endmodule

// File: tb/tb_fetch_redirect_unit.sv
// Directed checks of fetch_redirect_unit with RESET_VECTOR=0x100 and 4-bit counters.
module tb_fetch_redirect_unit;

  localparam int CNT_W = 4;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_pass;

  fetch_redirect_unit_if #(.CNT_W(CNT_W)) bus ();

  fetch_redirect_unit #(
    .RESET_VECTOR (32'h0000_0100),
    .CNT_W        (CNT_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_state(input string tag, input logic [31:0] pc, input logic boot,
                           input logic redir, input logic mis,
                           input logic [CNT_W-1:0] bc, input logic [CNT_W-1:0] mc);
    check({tag, ".pcf"},   bus.PCF, pc);
    check({tag, ".boot"},  {31'd0, bus.BootF}, {31'd0, boot});
    check({tag, ".redir"}, {31'd0, bus.RedirectF}, {31'd0, redir});
    check({tag, ".mis"},   {31'd0, bus.MisalignF}, {31'd0, mis});
    check({tag, ".bcnt"},  {28'd0, bus.BranchCnt}, {28'd0, bc});
    check({tag, ".mcnt"},  {28'd0, bus.MispredCnt}, {28'd0, mc});
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    reset = 1'b1;
    bus.StallF = 1'b0; bus.StallE = 1'b0; bus.PCSrc = 2'b00;
    bus.PredPCTargetF = 32'h0; bus.PCTargetE = 32'h0; bus.PCPlus4E = 32'h0;
    bus.BranchOpE = 2'b00; bus.CntClr = 1'b0;

    step();
    chk_state("reset", 32'h100, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0);
    reset = 1'b0;
    #1;
    chk_state("boot0", 32'h100, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0);
    check("pcplus4_boot", bus.PCPlus4F, 32'h104);

    // Sequential fetch after boot
    step(); chk_state("seq1", 32'h100, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
    step(); check("seq2.pcf", bus.PCF, 32'h104);
    step(); check("seq3.pcf", bus.PCF, 32'h108);

    // Predicted target is not a redirect
    bus.PCSrc = 2'b01; bus.PredPCTargetF = 32'h200;
    step(); chk_state("pred", 32'h200, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);

    // Taken mispredict overrides StallF, then back-to-back not-taken mispredict
    bus.PCSrc = 2'b10; bus.PCTargetE = 32'h340; bus.BranchOpE = 2'b01; bus.StallF = 1'b1;
    step(); chk_state("redir1", 32'h340, 1'b0, 1'b1, 1'b0, 4'd1, 4'd1);
    bus.PCSrc = 2'b11; bus.PCPlus4E = 32'h124; bus.BranchOpE = 2'b00;
    step(); chk_state("redir2", 32'h124, 1'b0, 1'b1, 1'b0, 4'd1, 4'd2);
    bus.PCSrc = 2'b00; bus.StallF = 1'b0;
    step(); chk_state("after_redir", 32'h128, 1'b0, 1'b0, 1'b0, 4'd1, 4'd2);

    // Redirect held back by StallE with StallF also high
    bus.PCSrc = 2'b10; bus.PCTargetE = 32'h400; bus.BranchOpE = 2'b01;
    bus.StallE = 1'b1; bus.StallF = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(); chk_state("stallE", 32'h128, 1'b0, 1'b0, 1'b0, 4'd1, 4'd2);
    end
    bus.StallE = 1'b0;
    step(); chk_state("stallE_rel", 32'h400, 1'b0, 1'b1, 1'b0, 4'd2, 4'd3);
    bus.PCSrc = 2'b00; bus.StallF = 1'b0; bus.BranchOpE = 2'b00;
    step(); chk_state("stallE_post", 32'h404, 1'b0, 1'b0, 1'b0, 4'd2, 4'd3);

    // E-side select with StallE but StallF low: loads, not counted
    bus.PCSrc = 2'b11; bus.PCPlus4E = 32'h500; bus.StallE = 1'b1;
    step(); chk_state("e_unacc", 32'h500, 1'b0, 1'b0, 1'b0, 4'd2, 4'd3);
    bus.StallE = 1'b0;

    // Saturation of MispredCnt, then CntClr wins over a same-cycle redirect
    bus.PCSrc = 2'b10; bus.PCTargetE = 32'h600;
    for (int i = 0; i < 20; i++) step();
    chk_state("sat", 32'h600, 1'b0, 1'b1, 1'b0, 4'd2, 4'hF);
    bus.CntClr = 1'b1;
    step(); chk_state("clr", 32'h600, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0);
    bus.CntClr = 1'b0; bus.PCSrc = 2'b00;
    step(); chk_state("clr_post", 32'h604, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);

    // Misaligned load sets sticky flag; aligned loads keep it; CntClr drops it
    bus.PCSrc = 2'b01; bus.PredPCTargetF = 32'h202;
    step(); chk_state("mis_set", 32'h202, 1'b0, 1'b0, 1'b1, 4'd0, 4'd0);
    bus.PredPCTargetF = 32'h300;
    step(); chk_state("mis_hold", 32'h300, 1'b0, 1'b0, 1'b1, 4'd0, 4'd0);
    bus.PCSrc = 2'b00;
    step(); check("mis_hold2.mis", {31'd0, bus.MisalignF}, 32'd1);
    bus.CntClr = 1'b1;
    step(); check("mis_clr.mis", {31'd0, bus.MisalignF}, 32'd0);
    bus.CntClr = 1'b0;
    bus.PCSrc = 2'b01; bus.PredPCTargetF = 32'h0000_0401;
    step(); check("mis_reset.mis", {31'd0, bus.MisalignF}, 32'd1);

    // Address wrap of PCPlus4F
    bus.PredPCTargetF = 32'hFFFF_FFFC;
    step(); check("wrap.pcplus4", bus.PCPlus4F, 32'h0);
    bus.PCSrc = 2'b00;
    step(); check("wrap.pcf", bus.PCF, 32'h0);

    // Mid-stream reset discards a pending redirect; BOOT ignores it too
    bus.PCSrc = 2'b10; bus.PCTargetE = 32'h700; bus.BranchOpE = 2'b10;
    reset = 1'b1;
    #1;
    chk_state("midrst", 32'h100, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0);
    step();
    reset = 1'b0;
    #1;
    step(); chk_state("boot_ign", 32'h100, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
    step(); chk_state("post_boot", 32'h700, 1'b0, 1'b1, 1'b0, 4'd1, 4'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
